// File: rtl/fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fp16_accumulator
// Purpose  : Sums groups of len FP16 beats (truncating adder, sticky overflow).
//            Optional macro FP16_ACC_RELU_EN clamps negative results to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             ovf
);

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_accum = 2'd1;
    localparam logic [1:0]       c_out   = 2'd2;
    localparam logic [LEN_W-1:0] c_one   = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [15:0]      r_acc;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len_q;
    logic             r_ovf;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [LEN_W-1:0] w_count_inc;
    logic [LEN_W-1:0] w_len_sat;

    logic [4:0]  w_ea, w_eb, w_e_big;
    logic [10:0] w_ma, w_mb, w_m_big, w_m_small;
    logic        w_s_big, w_s_small, w_s_res;
    logic [11:0] w_m_sum;
    logic [10:0] w_m_norm;
    logic [5:0]  w_e_res;
    logic [15:0] w_sum;
    logic        w_sum_ovf;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_count_inc = r_count + c_one;
    assign w_len_sat   = (len == '0) ? c_one : len;

    // Truncating FP16 adder: exponent-0 operands count as zero, no rounding.
    always_comb begin
        w_ea = r_acc[14:10];
        w_eb = in_data[14:10];
        w_ma = (w_ea == 5'd0) ? 11'd0 : {1'b1, r_acc[9:0]};
        w_mb = (w_eb == 5'd0) ? 11'd0 : {1'b1, in_data[9:0]};
        if (w_ea >= w_eb) begin
            w_e_big   = w_ea;
            w_m_big   = w_ma;
            w_s_big   = r_acc[15];
            w_m_small = w_mb >> (w_ea - w_eb);
            w_s_small = in_data[15];
        end else begin
            w_e_big   = w_eb;
            w_m_big   = w_mb;
            w_s_big   = in_data[15];
            w_m_small = w_ma >> (w_eb - w_ea);
            w_s_small = r_acc[15];
        end

        if (w_s_big == w_s_small) begin
            w_m_sum = {1'b0, w_m_big} + {1'b0, w_m_small};
            w_s_res = w_s_big;
        end else if (w_m_big >= w_m_small) begin
            w_m_sum = {1'b0, w_m_big} - {1'b0, w_m_small};
            w_s_res = w_s_big;
        end else begin
            w_m_sum = {1'b0, w_m_small} - {1'b0, w_m_big};
            w_s_res = w_s_small;
        end

        w_e_res  = {1'b0, w_e_big};
        w_m_norm = w_m_sum[10:0];
        if (w_m_sum[11]) begin
            w_m_norm = w_m_sum[11:1];
            w_e_res  = w_e_res + 6'd1;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (!w_m_norm[10] && (w_e_res != 6'd0)) begin
                    w_m_norm = w_m_norm << 1;
                    w_e_res  = w_e_res - 6'd1;
                end
            end
        end

        w_sum_ovf = 1'b0;
        if (w_m_sum == 12'd0) begin
            w_sum = 16'h0000;
        end else if (w_e_res >= 6'd31) begin
            w_sum     = {w_s_res, 15'h7C00};
            w_sum_ovf = 1'b1;
        end else begin
            w_sum = {w_s_res, w_e_res[4:0], w_m_norm[9:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_in_fire) w_next = (w_len_sat == c_one) ? c_out : c_accum;
            c_accum: if (w_in_fire && (w_count_inc == r_len_q)) w_next = c_out;
            c_out:   if (w_out_fire) w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Handshakes are gated by rst so nothing is offered or taken during reset.
    always_comb begin
        in_ready  = !rst && (r_state != c_out);
        out_valid = !rst && (r_state == c_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= 16'h0000;
            r_count <= '0;
            r_len_q <= c_one;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: if (w_in_fire) begin
                    r_acc   <= in_data;
                    r_count <= c_one;
                    r_len_q <= w_len_sat;
                    r_ovf   <= 1'b0;
                end
                c_accum: if (w_in_fire) begin
                    r_acc   <= w_sum;
                    r_count <= w_count_inc;
                    if (w_sum_ovf) r_ovf <= 1'b1;
                end
                c_out: if (w_out_fire) r_ovf <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ovf = r_ovf;

`ifdef FP16_ACC_RELU_EN
    assign out_data = r_acc[15] ? 16'h0000 : r_acc;
`else
    assign out_data = r_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_accumulator
// Purpose  : Scoreboard bench for fp16_accumulator with a behavioural FP16 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_accumulator;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ready_random = 1'b0;
    bit ready_force  = 1'b1;
    logic [16:0] exp_q[$];   // {ovf, data}

    fp16_accumulator #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Value-level FP16 sum following the truncating rules, using plain integers.
    function automatic void fp_add(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output bit o);
        int ea, eb, ma, mb, e, ml, ms, m, sl, ss, s;
        ea = a[14:10]; eb = b[14:10];
        ma = (ea == 0) ? 0 : 1024 + a[9:0];
        mb = (eb == 0) ? 0 : 1024 + b[9:0];
        if (ea >= eb) begin
            e = ea; ml = ma; sl = a[15]; ms = mb >> (ea - eb); ss = b[15];
        end else begin
            e = eb; ml = mb; sl = b[15]; ms = ma >> (eb - ea); ss = a[15];
        end
        if (sl == ss)      begin m = ml + ms; s = sl; end
        else if (ml >= ms) begin m = ml - ms; s = sl; end
        else               begin m = ms - ml; s = ss; end
        o = 1'b0;
        if (m == 0) begin
            r = 16'h0000;
        end else begin
            if (m >= 2048) begin
                m = m / 2; e = e + 1;
            end else begin
                while (m < 1024 && e > 0) begin m = m * 2; e = e - 1; end
            end
            if (e >= 31) begin
                r = (s != 0) ? 16'hFC00 : 16'h7C00;
                o = 1'b1;
            end else begin
                r = 16'((s << 15) | (e << 10) | (m % 1024));
            end
        end
    endfunction

    function automatic logic [16:0] model_group(input int n_len, input logic [15:0] beats[$]);
        logic [15:0] acc, nxt;
        bit o, sticky;
        int n;
        n = (n_len == 0) ? 1 : n_len;
        acc = beats[0];
        sticky = 1'b0;
        for (int i = 1; i < n; i++) begin
            fp_add(acc, beats[i], nxt, o);
            acc = nxt;
            if (o) sticky = 1'b1;
        end
`ifdef FP16_ACC_RELU_EN
        if (acc[15]) acc = 16'h0000;
`endif
        return {sticky, acc};
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic [LEN_W-1:0] l);
        logic ok;
        int tmo;
        in_valid = 1'b1; in_data = d; len = l;
        tmo = 0;
        forever begin
            @(negedge clk); ok = in_ready;
            @(posedge clk);
            if (ok) break;
            tmo++;
            if (tmo > 300) begin
                checks++; errors++;
                $display("FAIL beat_accept_timeout: in_ready stayed 0, required 1");
                break;
            end
        end
        #1;
    endtask

    task automatic send_group(input int l, input logic [15:0] beats[$]);
        int n;
        n = (l == 0) ? 1 : l;
        exp_q.push_back(model_group(l, beats));
        for (int i = 0; i < n; i++) send_beat(beats[i], LEN_W'(l));
        in_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: pops and compares on every taken result.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got data 0x%0h with empty scoreboard", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", 32'(out_data), 32'(e[15:0]));
                    check("result_ovf", 32'(ovf), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        logic [15:0] b[$];
        logic [15:0] held;
        int c0, c3, tmo;
        rst = 1'b1; len = '0; in_valid = 1'b0; in_data = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h0000);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Four back-to-back ones: latency and throughput.
        exp_q.push_back({1'b0, 16'h4400});
        send_beat(16'h3C00, 8'd4); c0 = cyc;
        send_beat(16'h3C00, 8'd4);
        send_beat(16'h3C00, 8'd4);
        send_beat(16'h3C00, 8'd4); c3 = cyc;
        in_valid = 1'b0;
        check("back_to_back_cycles", 32'(c3 - c0), 32'd3);
        @(negedge clk);
        check("out_valid_next_cycle", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        b = '{16'h4000, 16'hBC00}; exp_q.push_back({1'b0, 16'h3C00}); send_group(2, b); void'(exp_q.pop_back());
        b = '{16'h3C00, 16'hBC00}; send_group(2, b); exp_q[exp_q.size()-1] = {1'b0, 16'h0000};
`ifdef FP16_ACC_RELU_EN
        exp_q.push_back({1'b0, 16'h0000});
`else
        exp_q.push_back({1'b0, 16'hC000});
`endif
        send_beat(16'hC000, 8'd1); in_valid = 1'b0;
        exp_q.push_back({1'b0, 16'h4200}); send_beat(16'h4200, 8'd0); in_valid = 1'b0;
        exp_q.push_back({1'b1, 16'h7C00});
        send_beat(16'h7BFF, 8'd2); send_beat(16'h7BFF, 8'd2); in_valid = 1'b0;

        // Consumer stall: result must hold and inputs must be refused.
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 200) begin @(posedge clk); tmo++; end
        check("drain_before_stall", 32'(exp_q.size()), 32'd0);
        ready_force = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 16'h4000});
        send_beat(16'h3C00, 8'd2); send_beat(16'h3C00, 8'd2);
        in_valid = 1'b1; in_data = 16'h1234; len = 8'd3;
        @(negedge clk); held = out_data;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_data_stable", 32'(out_data), 32'(held));
            @(negedge clk);
        end
        check("stall_data_value", 32'(held), 32'h4000);
        in_valid = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;

        // Reset mid-group discards the partial sum.
        send_beat(16'h3C00, 8'd4); send_beat(16'h3C00, 8'd4); in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 16'h3C00}); send_beat(16'h3C00, 8'd1); in_valid = 1'b0;

        // Randomized groups with a randomly stalling consumer.
        ready_random = 1'b1;
        for (int g = 0; g < 60; g++) begin
            int l;
            l = $urandom_range(0, 6);
            b.delete();
            for (int i = 0; i < ((l == 0) ? 1 : l); i++) begin
                if ($urandom_range(0, 3) == 0)
                    b.push_back(16'($urandom_range(0, 65535)));
                else
                    b.push_back({1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))});
            end
            send_group(l, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        tmo = 0;
        while (exp_q.size() != 0 && tmo < 2000) begin @(posedge clk); tmo++; end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_accumulator.md
FP16_ACCUMULATOR -- requirements
Module: fp16_accumulator

Interface
REQ-001 SHALL have parameter LEN_W, default 8, the width of the group-length input.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port len, input, LEN_W bits, the number of beats per group, sampled on the first beat of each group.
REQ-005 SHALL have port in_valid, input, 1 bit, asserted when in_data holds an FP16 operand.
REQ-006 SHALL have port in_ready, output, 1 bit, asserted when the block accepts a beat.
REQ-007 SHALL have port in_data, input, 16 bits, FP16 operand.
REQ-008 SHALL have port out_valid, output, 1 bit, asserted when out_data holds a completed group sum.
REQ-009 SHALL have port out_ready, input, 1 bit, asserted when the consumer accepts the result.
REQ-010 SHALL have port out_data, output, 16 bits, FP16 group sum.
REQ-011 SHALL have port ovf, output, 1 bit, sticky overflow flag for the current result.

Function
REQ-012 SHALL treat a beat as accepted when in_valid and in_ready are both high at a rising edge, and a result as taken when out_valid and out_ready are both high.
REQ-013 SHALL implement FSM IDLE, ACCUM and OUT, with in_ready = 1 in IDLE and ACCUM and 0 in OUT, and out_valid = 1 only in OUT.
REQ-014 SHALL, in IDLE on an accepted beat, load acc = in_data, set count = 1 and latch len_q = max(len, 1), then go to OUT if len_q == 1 and otherwise to ACCUM.
REQ-015 SHALL, in ACCUM on an accepted beat, set acc = acc + in_data and increment count, going to OUT when the new count equals len_q.
REQ-016 SHALL, in OUT, hold out_data = acc and hold ovf stable until the result is taken, then return to IDLE.
REQ-017 SHALL assert out_valid on the cycle after the last beat is accepted, give a throughput of 1 beat per cycle within a group, and leave 1 idle-input cycle per group, since no input beat is accepted while in OUT.
REQ-018 SHALL perform the FP16 add combinationally in 1 cycle as follows:
- operands with exponent 0 are treated as zero;
- the smaller-exponent operand's 11-bit mantissa (implicit 1) is right-shifted by the exponent difference with truncation;
- equal signs add the magnitudes;
- unequal signs subtract the smaller magnitude from the larger and take the sign of the larger;
- an exact zero difference gives 0x0000.
REQ-019 SHALL hold the add's mantissa sum in 12 bits; a carry into bit 11 shifts right 1 and increments the exponent, and otherwise the sum is left-normalised until bit 10 is set or the exponent reaches 0.
REQ-020 SHALL, on a result exponent >= 31, set acc to the signed infinity (0x7C00 or 0xFC00) and set ovf, which stays set until the group is taken.
REQ-021 SHALL perform no rounding and SHALL give no special treatment to NaN or infinity inputs beyond REQ-018.

Reset
REQ-022 SHALL, while rst is high, force the state to IDLE and set acc = 0x0000, count = 0, len_q = 1, ovf = 0 and out_valid = 0; in_ready SHALL read 0 while rst is high.
REQ-023 SHALL, on a reset asserted mid-group or in OUT, discard the partial or pending sum, and the first beat after reset SHALL start a new group.

Configuration
REQ-024 SHALL, with macro FP16_ACC_RELU_EN defined, present out_data = 0x0000 whenever acc has its sign bit set (a ReLU applied at the output only, with acc itself unchanged).
REQ-025 SHALL, with FP16_ACC_RELU_EN undefined, present out_data = acc unmodified.

Verification
REQ-026 SHALL cover: len=4, beats 0x3C00 x4 back-to-back -> out_valid on the cycle after beat 4, out_data=0x4400, ovf=0.
REQ-027 SHALL cover: len=2, beats 0x4000 then 0xBC00 -> out_data=0x3C00; and len=2, beats 0x3C00 then 0xBC00 -> out_data=0x0000.
REQ-028 SHALL cover: len=1, beat 0xC000 -> out_data=0xC000 without the macro, and 0x0000 with FP16_ACC_RELU_EN.
REQ-029 SHALL cover: len=2, result ready, out_ready held low for 5 cycles -> out_data stable, in_ready=0, and in_valid beats not accepted.
REQ-030 SHALL cover: len=4, rst pulsed after 2 beats, then len=1 with beat 0x3C00 -> out_data=0x3C00 and no stale sum.
REQ-031 SHALL cover: len=0, beat 0x4200 -> single-beat group with out_data=0x4200; and len=2, beats 0x7BFF twice -> out_data=0x7C00, ovf=1.
